rotor2_fwd: RTL and testbench

- Forward (entry-side) path of rotor 2: the plaintext-direction counterpart of the rotor-2 inverse stage.
- Owns rotor 2's position register, which the inverse stage reads as its `rotate` input.
- Applies stepping (carry from rotor 1, optional double-step), maps letters through rotor-II wiring plus position offset, and emits carry to rotor 3.
- Letters are encoded 1..26 (A=1 .. Z=26); 0 means invalid.

---
 rtl/rotor2_fwd.sv | 120 ++++++++++++
 tb/tb_rotor2_fwd.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rotor2_fwd.sv
// Rotor-2 forward path: owns the rotor position, steps it on carry from rotor 1,
// encodes letters through the rotor-II wiring and emits carry to rotor 3.
// Optional Enigma middle-rotor double-step is enabled by `define ROTOR2_DOUBLE_STEP_EN.
module rotor2_fwd #(
   parameter int unsigned NOTCH     = 4,
   parameter int unsigned RESET_POS = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [4:0] load_pos,
   input  logic       step_in,
   input  logic       key_strobe,
   input  logic       in_valid,
   input  logic [4:0] in,
   output logic       out_valid,
   output logic [4:0] out,
   output logic [4:0] position,
   output logic       carry_out,
   output logic       err
);

   localparam logic [4:0] NOTCH_P = 5'(NOTCH);
   localparam logic [4:0] RESET_P = 5'(RESET_POS);

   // Rotor-II forward wiring; exact inverse of the rotor-2 inverse stage map.
   function automatic logic [4:0] fwd_map(input logic [4:0] x);
      case (x)
         5'd1:  fwd_map = 5'd6;
         5'd2:  fwd_map = 5'd15;
         5'd3:  fwd_map = 5'd11;
         5'd4:  fwd_map = 5'd21;
         5'd5:  fwd_map = 5'd4;
         5'd6:  fwd_map = 5'd1;
         5'd7:  fwd_map = 5'd26;
         5'd8:  fwd_map = 5'd14;
         5'd9:  fwd_map = 5'd17;
         5'd10: fwd_map = 5'd16;
         5'd11: fwd_map = 5'd24;
         5'd12: fwd_map = 5'd23;
         5'd13: fwd_map = 5'd2;
         5'd14: fwd_map = 5'd10;
         5'd15: fwd_map = 5'd9;
         5'd16: fwd_map = 5'd5;
         5'd17: fwd_map = 5'd8;
         5'd18: fwd_map = 5'd3;
         5'd19: fwd_map = 5'd13;
         5'd20: fwd_map = 5'd19;
         5'd21: fwd_map = 5'd7;
         5'd22: fwd_map = 5'd12;
         5'd23: fwd_map = 5'd18;
         5'd24: fwd_map = 5'd25;
         5'd25: fwd_map = 5'd20;
         5'd26: fwd_map = 5'd22;
         default: fwd_map = 5'd1;
      endcase
   endfunction

   logic       in_legal;
   logic       load_ok;
   logic       ds_req;
   logic       step_take;
   logic [5:0] sum;
   logic [5:0] sum_mod;
   logic [4:0] enc_letter;
   logic [4:0] pos_next;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      in_legal   = 1'b0;
      load_ok    = 1'b0;
      ds_req     = 1'b0;
      sum        = 6'd0;
      sum_mod    = 6'd0;
      enc_letter = 5'd0;
      pos_next   = 5'd0;

      in_legal = (in >= 5'd1) && (in <= 5'd26);
      load_ok  = (load_pos <= 5'd25);

`ifdef ROTOR2_DOUBLE_STEP_EN
      ds_req = key_strobe && (position == NOTCH_P);
`else
      ds_req = key_strobe & 1'b0;
`endif

      step_take = !load && (step_in || ds_req);

      // Zero-based wiring output plus offset never exceeds 50, so one subtract wraps it.
      sum        = {1'b0, fwd_map(in)} - 6'd1 + {1'b0, position};
      sum_mod    = (sum >= 6'd26) ? (sum - 6'd26) : sum;
      enc_letter = sum_mod[4:0] + 5'd1;

      pos_next = (position == 5'd25) ? 5'd0 : (position + 5'd1);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         position  <= RESET_P;
         out       <= 5'd0;
         out_valid <= 1'b0;
         carry_out <= 1'b0;
         err       <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid)
            out <= in_legal ? enc_letter : 5'd0;
         err       <= (in_valid && !in_legal) || (load && !load_ok);
         carry_out <= step_take && (position == NOTCH_P);
         if (load) begin
            if (load_ok)
               position <= load_pos;
         end else if (step_take) begin
            position <= pos_next;
         end
      end
   end

endmodule

// File: tb/tb_rotor2_fwd.sv
// Directed self-checking bench for rotor2_fwd: encode values, stepping, carry,
// error handling, reset and a full forward/inverse round-trip sweep.
module tb_rotor2_fwd;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load;
   logic [4:0] load_pos;
   logic       step_in;
   logic       key_strobe;
   logic       in_valid;
   logic [4:0] in;
   logic       out_valid;
   logic [4:0] out;
   logic [4:0] position;
   logic       carry_out;
   logic       err;

   int n_vec = 0;
   int n_err = 0;

   // Hand-derived inverse of the rotor-II wiring, index = letter 1..26.
   int inv_tab [0:26] = '{0, 6, 13, 18, 5, 16, 1, 21, 17, 15, 14, 3, 22, 19, 8, 2,
                          10, 9, 23, 20, 25, 4, 26, 12, 11, 24, 7};

   rotor2_fwd #(.NOTCH(4), .RESET_POS(0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .load_pos   (load_pos),
      .step_in    (step_in),
      .key_strobe (key_strobe),
      .in_valid   (in_valid),
      .in         (in),
      .out_valid  (out_valid),
      .out        (out),
      .position   (position),
      .carry_out  (carry_out),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int observed, input int expected);
      n_vec++;
      assert (observed === expected)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      load = 1'b0; load_pos = 5'd0; step_in = 1'b0; key_strobe = 1'b0;
      in_valid = 1'b0; in = 5'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int exp_pos;
      int back;

      idle();
      rst_n = 1'b0;
      #2;
      check("rst_position", position, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_carry", carry_out, 0);
      check("rst_err", err, 0);
      check("rst_out", out, 0);
      #6 rst_n = 1'b1;
      tick();

      in_valid = 1'b1; in = 5'd1;
      tick();
      check("enc_p0_A", out, 6);
      check("enc_p0_A_valid", out_valid, 1);
      check("enc_p0_A_err", err, 0);
      in = 5'd7;
      tick();
      check("enc_p0_G", out, 26);
      idle();
      tick();
      check("idle_valid", out_valid, 0);
      check("idle_hold", out, 26);

      load = 1'b1; load_pos = 5'd3;
      tick();
      check("load3_pos", position, 3);
      check("load3_carry", carry_out, 0);
      idle(); in_valid = 1'b1; in = 5'd1;
      tick();
      check("enc_p3_A", out, 9);

      idle(); load = 1'b1; load_pos = 5'd25;
      tick();
      idle(); in_valid = 1'b1; in = 5'd7;
      tick();
      check("enc_p25_G", out, 25);

      idle(); load = 1'b1; load_pos = 5'd4;
      tick();
      idle(); step_in = 1'b1;
      tick();
      check("step_notch_pos", position, 5);
      check("step_notch_carry", carry_out, 1);
      idle();
      tick();
      check("carry_one_cycle", carry_out, 0);
      check("pos_hold", position, 5);

      load = 1'b1; load_pos = 5'd25;
      tick();
      idle(); step_in = 1'b1;
      tick();
      check("wrap_pos", position, 0);
      check("wrap_carry", carry_out, 0);

      idle(); load = 1'b1; load_pos = 5'd4;
      tick();
      idle(); key_strobe = 1'b1;
      tick();
`ifdef ROTOR2_DOUBLE_STEP_EN
      exp_pos = 5;
      check("dstep_carry", carry_out, 1);
`else
      exp_pos = 4;
      check("dstep_carry", carry_out, 0);
`endif
      check("dstep_pos", position, exp_pos);
      idle();
      tick();
      check("dstep_carry_clear", carry_out, 0);

      in_valid = 1'b1; in = 5'd0;
      tick();
      check("bad_in0_out", out, 0);
      check("bad_in0_valid", out_valid, 1);
      check("bad_in0_err", err, 1);
      in = 5'd27;
      tick();
      check("bad_in27_out", out, 0);
      check("bad_in27_err", err, 1);
      idle();
      tick();
      check("err_clear", err, 0);

      load = 1'b1; load_pos = 5'd30;
      tick();
      check("bad_load_pos", position, exp_pos);
      check("bad_load_err", err, 1);
      idle();
      tick();
      check("bad_load_err_clear", err, 0);

      load = 1'b1; load_pos = 5'd4;
      tick();
      load = 1'b1; load_pos = 5'd10; step_in = 1'b1;
      tick();
      check("load_wins_pos", position, 10);
      check("load_wins_carry", carry_out, 0);

      idle(); load = 1'b1; load_pos = 5'd4;
      tick();
      idle(); step_in = 1'b1; key_strobe = 1'b1;
      tick();
      check("both_req_pos", position, 5);
      check("both_req_carry", carry_out, 1);
      idle();
      tick();
      check("both_req_single", carry_out, 0);

      load = 1'b1; load_pos = 5'd4;
      tick();
      idle(); step_in = 1'b1; in_valid = 1'b1; in = 5'd2;
      tick();
      check("pre_rst_carry", carry_out, 1);
      check("pre_rst_valid", out_valid, 1);
      idle();
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_carry", carry_out, 0);
      check("mid_rst_out", out, 0);
      check("mid_rst_pos", position, 0);
      #3 rst_n = 1'b1;
      tick();

      for (int p = 0; p < 26; p++) begin
         idle(); load = 1'b1; load_pos = 5'(p);
         tick();
         idle();
         for (int l = 1; l <= 26; l++) begin
            in_valid = 1'b1; in = 5'(l);
            tick();
            back = inv_tab[((int'(out) - 1 - p + 26) % 26) + 1];
            check($sformatf("sweep_p%0d_l%0d", p, l), back, l);
         end
      end
      idle();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
